wb_pipe_stage: RTL and testbench

WB_PIPE_STAGE -- requirements
Module: wb_pipe_stage

---
 rtl/wb_pipe_stage.sv | 177 +++++++++++++++++
 tb/tb_wb_pipe_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_pipe_stage.sv
// Write-back stage as a 2-entry skid buffer (EMPTY/ONE/TWO) with registered outputs.
// Optional forwarding port enabled by macro WB_PIPE_FWD_EN (otherwise fwd_* tied to 0).
// Ports: clk, reset (async, active-low), flush; in_valid/in_ready plus the
// cache_result, destReg_addr_input, we_input and bp_input payload;
// out_valid/out_ready plus the wb_result, destReg_addr_output, we_output and
// bp_output payload; fwd_valid, fwd_addr and fwd_data.
module wb_pipe_stage #(
  parameter int DATA_W  = 16,
  parameter int RADDR_W = 3,
  parameter int BP_W    = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  cache_result,
  input  logic [RADDR_W-1:0] destReg_addr_input,
  input  logic               we_input,
  input  logic [BP_W-1:0]    bp_input,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  wb_result,
  output logic [RADDR_W-1:0] destReg_addr_output,
  output logic               we_output,
  output logic [BP_W-1:0]    bp_output,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]  fwd_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t r_state, w_nxt_state;

  logic [DATA_W-1:0]  r_h_data, r_t_data, w_nh_data, w_nt_data;
  logic [RADDR_W-1:0] r_h_addr, r_t_addr, w_nh_addr, w_nt_addr;
  logic               r_h_we, r_t_we, w_nh_we, w_nt_we;
  logic [BP_W-1:0]    r_h_bp, r_t_bp, w_nh_bp, w_nt_bp;
  logic               r_in_ready, r_out_valid;
  logic               w_acc, w_con;

  assign w_acc = in_valid & r_in_ready;
  assign w_con = r_out_valid & out_ready;

  always_comb begin
    w_nxt_state = r_state;
    w_nh_data   = r_h_data;
    w_nh_addr   = r_h_addr;
    w_nh_we     = r_h_we;
    w_nh_bp     = r_h_bp;
    w_nt_data   = r_t_data;
    w_nt_addr   = r_t_addr;
    w_nt_we     = r_t_we;
    w_nt_bp     = r_t_bp;
    unique case (r_state)
      EMPTY: begin
        if (w_acc) begin
          w_nxt_state = ONE;
          w_nh_data   = cache_result;
          w_nh_addr   = destReg_addr_input;
          w_nh_we     = we_input;
          w_nh_bp     = bp_input;
        end
      end
      ONE: begin
        if (w_acc && w_con) begin
          // head leaves and the new entry takes its place
          w_nh_data = cache_result;
          w_nh_addr = destReg_addr_input;
          w_nh_we   = we_input;
          w_nh_bp   = bp_input;
        end else if (w_acc) begin
          w_nxt_state = TWO;
          w_nt_data   = cache_result;
          w_nt_addr   = destReg_addr_input;
          w_nt_we     = we_input;
          w_nt_bp     = bp_input;
        end else if (w_con) begin
          w_nxt_state = EMPTY;
          w_nh_we     = 1'b0;
        end
      end
      TWO: begin
        if (w_con) begin
          w_nxt_state = ONE;
          w_nh_data   = r_t_data;
          w_nh_addr   = r_t_addr;
          w_nh_we     = r_t_we;
          w_nh_bp     = r_t_bp;
          w_nt_we     = 1'b0;
        end
      end
      default: begin
        w_nxt_state = EMPTY;
        w_nh_we     = 1'b0;
        w_nt_we     = 1'b0;
      end
    endcase
    if (flush) begin
      w_nxt_state = EMPTY;
      w_nh_we     = 1'b0;
      w_nt_we     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= EMPTY;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_h_data    <= '0;
      r_h_addr    <= '0;
      r_h_we      <= 1'b0;
      r_h_bp      <= '0;
      r_t_data    <= '0;
      r_t_addr    <= '0;
      r_t_we      <= 1'b0;
      r_t_bp      <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_in_ready  <= (w_nxt_state != TWO);
      r_out_valid <= (w_nxt_state != EMPTY);
      r_h_data    <= w_nh_data;
      r_h_addr    <= w_nh_addr;
      r_h_we      <= w_nh_we;
      r_h_bp      <= w_nh_bp;
      r_t_data    <= w_nt_data;
      r_t_addr    <= w_nt_addr;
      r_t_we      <= w_nt_we;
      r_t_bp      <= w_nt_bp;
    end
  end

  assign in_ready            = r_in_ready;
  assign out_valid           = r_out_valid;
  assign wb_result           = r_h_data;
  assign destReg_addr_output = r_h_addr;
  assign we_output           = r_h_we;
  assign bp_output           = r_h_bp;

`ifdef WB_PIPE_FWD_EN
  logic               r_fwd_valid;
  logic [RADDR_W-1:0] r_fwd_addr;
  logic [DATA_W-1:0]  r_fwd_data;
  logic               w_young_hit;

  // a younger write to the head's register shadows the head value
  assign w_young_hit = (w_nxt_state == TWO) & w_nt_we &
                       (w_nt_addr == w_nh_addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fwd_valid <= 1'b0;
      r_fwd_addr  <= '0;
      r_fwd_data  <= '0;
    end else begin
      r_fwd_valid <= (w_nxt_state != EMPTY) & w_nh_we;
      r_fwd_addr  <= w_nh_addr;
      r_fwd_data  <= w_young_hit ? w_nt_data : w_nh_data;
    end
  end

  assign fwd_valid = r_fwd_valid;
  assign fwd_addr  = r_fwd_addr;
  assign fwd_data  = r_fwd_data;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Bench for wb_pipe_stage: queue-based reference model, per-cycle compare,
// directed literal scenarios and randomized traffic.
module tb_wb_pipe_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] cache_result;
  logic [2:0]  destReg_addr_input;
  logic        we_input;
  logic [1:0]  bp_input;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] wb_result;
  logic [2:0]  destReg_addr_output;
  logic        we_output;
  logic [1:0]  bp_output;
  logic        fwd_valid;
  logic [2:0]  fwd_addr;
  logic [15:0] fwd_data;

  wb_pipe_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .cache_result(cache_result),
    .destReg_addr_input(destReg_addr_input),
    .we_input(we_input), .bp_input(bp_input),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_result(wb_result),
    .destReg_addr_output(destReg_addr_output),
    .we_output(we_output), .bp_output(bp_output),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  a;
    logic        we;
    logic [1:0]  bp;
  } ent_t;

  ent_t q[$];
  bit   m_rdy;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // reference: a FIFO of at most two entries; ready reflects room after the edge
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_rdy = 1'b0;
    end else begin
      bit   acc, con;
      ent_t e;
      acc = in_valid && m_rdy;
      con = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (con) void'(q.pop_front());
        if (acc) begin
          e.d = cache_result; e.a = destReg_addr_input;
          e.we = we_input; e.bp = bp_input;
          q.push_back(e);
        end
      end
      m_rdy = (q.size() != 2);
    end
  end

  // compare every cycle, away from the active edge
  always @(negedge clk) begin
    bit          mv, fv;
    logic [15:0] fd;
    mv = q.size() > 0;
    chk("out_valid", {31'b0, out_valid}, {31'b0, mv});
    chk("in_ready", {31'b0, in_ready}, {31'b0, m_rdy});
    if (mv) begin
      chk("wb_result", {16'b0, wb_result}, {16'b0, q[0].d});
      chk("dest_addr", {29'b0, destReg_addr_output}, {29'b0, q[0].a});
      chk("we_output", {31'b0, we_output}, {31'b0, q[0].we});
      chk("bp_output", {30'b0, bp_output}, {30'b0, q[0].bp});
    end else begin
      chk("we_idle", {31'b0, we_output}, 32'd0);
    end
    fv = mv && q[0].we;
    fd = 16'h0;
    if (mv) begin
      fd = q[0].d;
      if (q.size() == 2 && q[1].we && q[1].a == q[0].a) fd = q[1].d;
    end
`ifdef WB_PIPE_FWD_EN
    chk("fwd_valid", {31'b0, fwd_valid}, {31'b0, fv});
    if (fv) begin
      chk("fwd_addr", {29'b0, fwd_addr}, {29'b0, q[0].a});
      chk("fwd_data", {16'b0, fwd_data}, {16'b0, fd});
    end
`else
    chk("fwd_off", {12'b0, fwd_valid, fwd_addr, fwd_data}, 32'd0);
`endif
  end

  task automatic drive(input logic v, input logic [15:0] d,
                       input logic [2:0] a, input logic w,
                       input logic [1:0] b);
    in_valid = v; cache_result = d; destReg_addr_input = a;
    we_input = w; bp_input = b;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rdy"}, {31'b0, in_ready}, 32'd0);
    chk({nm, "_vld"}, {31'b0, out_valid}, 32'd0);
    chk({nm, "_pay"}, {11'b0, we_output, wb_result, destReg_addr_output,
                       bp_output}, 32'd0);
    chk({nm, "_fwd"}, {12'b0, fwd_valid, fwd_addr, fwd_data}, 32'd0);
  endtask

  // edge, then sample 1 time unit later
  task automatic edge_s();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 16'h0, 3'h0, 1'b0, 2'h0);
    edge_s();
    edge_s();
    chk_zero("reset");
    #1 reset = 1'b1;
    #1 chk("rdy_before_edge", {31'b0, in_ready}, 32'd0);
    edge_s();
    chk("rdy_after_release", {31'b0, in_ready}, 32'd1);

    // single entry
    #1 drive(1'b1, 16'hBEEF, 3'd5, 1'b1, 2'd2);
    out_ready = 1'b1;
    edge_s();
    chk("single_vld", {31'b0, out_valid}, 32'd1);
    chk("single_data", {16'b0, wb_result}, 32'h0000BEEF);
    chk("single_addr", {29'b0, destReg_addr_output}, 32'd5);
    chk("single_we", {31'b0, we_output}, 32'd1);
    chk("single_bp", {30'b0, bp_output}, 32'd2);
    #1 drive(1'b0, 16'h0, 3'h0, 1'b0, 2'h0);
    edge_s();
    chk("single_pulse", {31'b0, out_valid}, 32'd0);
    chk("single_we_off", {31'b0, we_output}, 32'd0);

    // three back-to-back with a stalled consumer
    #1 out_ready = 1'b0;
    drive(1'b1, 16'h0011, 3'd3, 1'b1, 2'd0);
    edge_s();
    #1 drive(1'b1, 16'h0022, 3'd3, 1'b1, 2'd1);
    edge_s();
    #1 drive(1'b1, 16'h0033, 3'd1, 1'b1, 2'd3);
    edge_s();
    chk("full_rdy", {31'b0, in_ready}, 32'd0);
    chk("full_head", {16'b0, wb_result}, 32'h00000011);
`ifdef WB_PIPE_FWD_EN
    chk("fwd_young", {12'b0, fwd_valid, fwd_addr, fwd_data},
        {12'b0, 1'b1, 3'd3, 16'h0022});
`else
    chk("fwd_none", {12'b0, fwd_valid, fwd_addr, fwd_data}, 32'd0);
`endif
    edge_s();
    chk("held_head", {16'b0, wb_result}, 32'h00000011);

    // drain while third keeps being offered
    #1 out_ready = 1'b1;
    edge_s();
    chk("drain_2", {16'b0, wb_result}, 32'h00000022);
    edge_s();
    chk("drain_3", {16'b0, wb_result}, 32'h00000033);
    #1 drive(1'b0, 16'h0, 3'h0, 1'b0, 2'h0);
    edge_s();
    chk("drain_empty", {31'b0, out_valid}, 32'd0);

    // flush in TWO with a same-cycle accept attempt
    #1 out_ready = 1'b0;
    drive(1'b1, 16'h0044, 3'd2, 1'b1, 2'd0);
    edge_s();
    #1 drive(1'b1, 16'h0055, 3'd4, 1'b1, 2'd0);
    edge_s();
    #1 drive(1'b1, 16'h0066, 3'd6, 1'b1, 2'd0);
    flush = 1'b1;
    edge_s();
    chk("flush_vld", {31'b0, out_valid}, 32'd0);
    chk("flush_we", {31'b0, we_output}, 32'd0);
    chk("flush_rdy", {31'b0, in_ready}, 32'd1);
    #1 flush = 1'b0;
    drive(1'b0, 16'h0, 3'h0, 1'b0, 2'h0);
    edge_s();
    chk("flush_dropped", {31'b0, out_valid}, 32'd0);

    // randomized traffic with a mid-stream reset
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #2;
      drive($urandom_range(0, 9) < 7, 16'($urandom), 3'($urandom),
            1'($urandom), 2'($urandom));
      out_ready = $urandom_range(0, 9) < 6;
      flush = $urandom_range(0, 31) == 0;
      if (i == 1000) begin
        reset = 1'b0;
        #1 chk_zero("mid_reset");
      end
      if (i == 1003) reset = 1'b1;
    end

    @(posedge clk);
    #2;
    drive(1'b0, 16'h0, 3'h0, 1'b0, 2'h0);
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("final_empty", {31'b0, out_valid}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
